// File: rtl/maxpool_22.sv
// maxpool_22 -- 2x2 max-pooling, stride 2, no padding, over a square D x D
// raster-order stream of IEEE-754 single-precision pixels.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   valid_in   pxl_in is accepted on the rising edge when high
//   pxl_in     input pixel (data_width bits)
//   pxl_out    pooled pixel (max of one 2x2 window); holds when valid_out=0
//   valid_out  one-cycle strobe, one cycle after the completing pixel
//   frame_end  high with valid_out on the last pooled pixel of a frame
//
// Odd D: the last column and last row are consumed by the counters but
// contribute nothing to the output.
module maxpool_22 #(
  parameter int D          = 299,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_end
);

  localparam int HALF = D / 2;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST      = CW'(D - 1);
  localparam logic [CW-1:0] LAST_POOL = CW'(2 * HALF - 1);
  localparam bit D_ODD = (D % 2) != 0;
  localparam logic [data_width-1:0] SIGN_BIT = {1'b1, {(data_width-1){1'b0}}};

  // Sortable key: positives get the MSB set, negatives are inverted.
  // -0 is mapped onto the +0 key so the two compare equal.
  function automatic logic [data_width-1:0] sort_key(input logic [data_width-1:0] x);
    if (x == SIGN_BIT)
      sort_key = SIGN_BIT;
    else if (x[data_width-1])
      sort_key = ~x;
    else
      sort_key = x | SIGN_BIT;
  endfunction

  // Strictly greater: on a tie the earlier operand is kept bit-exact.
  function automatic logic later_wins(input logic [data_width-1:0] later,
                                      input logic [data_width-1:0] earlier);
    later_wins = sort_key(later) > sort_key(earlier);
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [data_width-1:0] pair_q, pair_d;
  logic [data_width-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_end_q, frame_end_d;

  // Line buffer holds the even-row pair maxima; never cleared, always
  // written in the even row before the odd row reads it.
  logic [data_width-1:0] lb [HALF];
  logic [KW-1:0]         lb_idx;
  logic                  lb_we;
  logic [data_width-1:0] lb_rdata;
  logic [data_width-1:0] pair_max;
  logic [data_width-1:0] win_max;
  logic                  col_ok;
  logic                  row_ok;

  assign lb_rdata = lb[lb_idx];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    pxl_out_d   = pxl_out_q;
    valid_out_d = 1'b0;
    frame_end_d = 1'b0;
    lb_we       = 1'b0;
    lb_idx      = KW'(col_q >> 1);
    pair_max    = later_wins(pxl_in, pair_q) ? pxl_in : pair_q;
    win_max     = later_wins(pair_max, lb_rdata) ? pair_max : lb_rdata;
    col_ok      = !D_ODD || (col_q != LAST);
    row_ok      = !D_ODD || (row_q != LAST);

    if (valid_in) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (col_ok && row_ok) begin
        if (!col_q[0]) begin
          pair_d = pxl_in;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          pxl_out_d   = win_max;
          valid_out_d = 1'b1;
          frame_end_d = (row_q == LAST_POOL) && (col_q == LAST_POOL);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      pxl_out_q   <= '0;
      valid_out_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      pxl_out_q   <= pxl_out_d;
      valid_out_q <= valid_out_d;
      frame_end_q <= frame_end_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb[lb_idx] <= pair_max;
  end

  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_maxpool_22.sv
module tb_maxpool_22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v4, v5;
  logic [31:0] p4, p5;
  logic [31:0] o4, o5;
  logic        vo4, vo5, fe4, fe5;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [31:0] last4 = 32'h0;

  maxpool_22 #(.D(4), .data_width(32)) dut4 (
    .clk(clk), .reset(reset), .valid_in(v4), .pxl_in(p4),
    .pxl_out(o4), .valid_out(vo4), .frame_end(fe4)
  );

  maxpool_22 #(.D(5), .data_width(32)) dut5 (
    .clk(clk), .reset(reset), .valid_in(v5), .pxl_in(p5),
    .pxl_out(o5), .valid_out(vo5), .frame_end(fe5)
  );

  // Integer n (1..2^23) to single-precision bits.
  function automatic logic [31:0] f32(input int unsigned n);
    int unsigned e = 0;
    logic [31:0] mant;
    while ((n >> (e + 1)) != 0) e++;
    mant = (32'(n) << (23 - e)) & 32'h007F_FFFF;
    return (32'(127 + e) << 23) | mant;
  endfunction

  task automatic step4(input logic v, input logic [31:0] p);
    v4 = v; p4 = p;
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic step5(input logic v, input logic [31:0] p);
    v5 = v; p5 = p;
    @(posedge clk); #1;
    v5 = 1'b0;
  endtask

  // One D=4 frame: px in raster order, ex = window maxima in raster order.
  task automatic run_frame4(input logic [31:0] px [16], input logic [31:0] ex [4],
                            input bit bubbles, input string name);
    int n = 0;
    while (n < 16) begin
      if (bubbles && $urandom_range(0, 1) == 0) begin
        step4(1'b0, 32'hDEAD_BEEF);
        vecs++;
        if (vo4 !== 1'b0 || o4 !== last4)
          $display("FAIL %s_bubble@%0d: valid_out=%b pxl_out=%h required valid_out=0 pxl_out=%h",
                   name, n, vo4, o4, last4);
        if (vo4 !== 1'b0 || o4 !== last4) errs++;
      end else begin
        int r = n / 4;
        int c = n % 4;
        logic exp_v = (r % 2 == 1) && (c % 2 == 1);
        step4(1'b1, px[n]);
        vecs++;
        if (vo4 !== exp_v) begin
          $display("FAIL %s_valid@%0d: got %b required %b", name, n, vo4, exp_v);
          errs++;
        end
        if (exp_v) begin
          logic [31:0] e = ex[(r / 2) * 2 + c / 2];
          vecs++;
          if (o4 !== e) begin
            $display("FAIL %s_pxl@%0d: got %h required %h", name, n, o4, e);
            errs++;
          end
          last4 = e;
        end
        vecs++;
        if (fe4 !== (n == 15)) begin
          $display("FAIL %s_frame_end@%0d: got %b required %b", name, n, fe4, (n == 15));
          errs++;
        end
        n++;
      end
    end
  endtask

  task automatic ramp_tables(output logic [31:0] px [16], output logic [31:0] ex [4]);
    for (int i = 0; i < 16; i++) px[i] = f32(i + 1);
    ex[0] = 32'h40C0_0000; ex[1] = 32'h4100_0000;
    ex[2] = 32'h4160_0000; ex[3] = 32'h4180_0000;
  endtask

  task automatic test_reset();
    reset = 1'b0; v4 = 1'b0; v5 = 1'b0; p4 = '0; p5 = '0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (o4  !== 32'h0) begin $display("FAIL reset_pxl4: got %h required 0", o4); errs++; end
    vecs++; if (vo4 !== 1'b0)  begin $display("FAIL reset_valid4: got %b required 0", vo4); errs++; end
    vecs++; if (fe4 !== 1'b0)  begin $display("FAIL reset_fe4: got %b required 0", fe4); errs++; end
    vecs++; if (o5  !== 32'h0) begin $display("FAIL reset_pxl5: got %h required 0", o5); errs++; end
    vecs++; if (vo5 !== 1'b0)  begin $display("FAIL reset_valid5: got %b required 0", vo5); errs++; end
    reset = 1'b1;
    last4 = 32'h0;
  endtask

  task automatic test_ramp4();
    logic [31:0] px [16];
    logic [31:0] ex [4];
    ramp_tables(px, ex);
    run_frame4(px, ex, 1'b0, "ramp4");
  endtask

  task automatic test_negative();
    logic [31:0] px [16];
    logic [31:0] ex [4];
    for (int i = 0; i < 16; i++) px[i] = 32'hBF80_0000;
    px[5] = 32'hBF00_0000;
    ex[0] = 32'hBF00_0000; ex[1] = 32'hBF80_0000;
    ex[2] = 32'hBF80_0000; ex[3] = 32'hBF80_0000;
    run_frame4(px, ex, 1'b0, "neg4");
  endtask

  task automatic test_signed_zero();
    logic [31:0] px [16];
    logic [31:0] ex [4];
    px[0] = 32'h0000_0000; px[1] = 32'h8000_0000; px[2] = 32'h8000_0000; px[3] = 32'h0000_0000;
    px[4] = 32'h8000_0000; px[5] = 32'h8000_0000; px[6] = 32'h0000_0000; px[7] = 32'h0000_0000;
    for (int i = 8; i < 16; i++) px[i] = 32'h3F80_0000;
    ex[0] = 32'h0000_0000; ex[1] = 32'h8000_0000;
    ex[2] = 32'h3F80_0000; ex[3] = 32'h3F80_0000;
    run_frame4(px, ex, 1'b0, "zero4");
  endtask

  task automatic test_odd_width();
    int outs = 0;
    for (int n = 0; n < 25; n++) begin
      int r = n / 5;
      int c = n % 5;
      logic exp_v = (r == 1 || r == 3) && (c == 1 || c == 3);
      step5(1'b1, f32(n + 1));
      vecs++;
      if (vo5 !== exp_v) begin
        $display("FAIL odd5_valid@%0d: got %b required %b", n, vo5, exp_v);
        errs++;
      end
      if (exp_v) begin
        logic [31:0] e;
        case (outs)
          0: e = 32'h40E0_0000;
          1: e = 32'h4110_0000;
          2: e = 32'h4188_0000;
          default: e = 32'h4198_0000;
        endcase
        outs++;
        vecs++;
        if (o5 !== e) begin
          $display("FAIL odd5_pxl@%0d: got %h required %h", n, o5, e);
          errs++;
        end
      end
      vecs++;
      if (fe5 !== (n == 18)) begin
        $display("FAIL odd5_frame_end@%0d: got %b required %b", n, fe5, (n == 18));
        errs++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] px [16];
    logic [31:0] ex [4];
    ramp_tables(px, ex);
    run_frame4(px, ex, 1'b1, "bubble_f1");
    run_frame4(px, ex, 1'b1, "bubble_f2");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] px [16];
    logic [31:0] ex [4];
    for (int n = 1; n <= 7; n++) step4(1'b1, f32(n));
    reset = 1'b0;
    #1;
    vecs++;
    if (vo4 !== 1'b0 || o4 !== 32'h0) begin
      $display("FAIL midreset_async: valid_out=%b pxl_out=%h required 0/00000000", vo4, o4);
      errs++;
    end
    v4 = 1'b1; p4 = f32(99);
    @(posedge clk); #1;
    v4 = 1'b0;
    vecs++;
    if (vo4 !== 1'b0 || fe4 !== 1'b0) begin
      $display("FAIL midreset_held: valid_out=%b frame_end=%b required 0/0", vo4, fe4);
      errs++;
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    last4 = 32'h0;
    ramp_tables(px, ex);
    run_frame4(px, ex, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_ramp4();
    test_negative();
    test_signed_zero();
    test_odd_width();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
